// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full_subtractor time-shared LSB first over WIDTH cycles.
// Optional overflow_o output is compiled in when SERIAL_SUB_OVERFLOW_EN is defined.

module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & (b_i | bin_i)) | (b_i & bin_i);
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow_o,
`endif
  output logic             borrow_out_o
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             r_a_msb;
  logic             r_b_msb;
`endif

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  full_subtractor u_fs (
    .a_i    (r_a[0]),
    .b_i    (r_b[0]),
    .bin_i  (r_borrow),
    .d_o    (w_d),
    .bout_o (w_bout)
  );

  // Result fills from the MSB end so after WIDTH shifts bit 0 lands in place.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_nxt = w_d;
    end else begin : g_res_wn
      assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_borrow     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      diff_o       <= '0;
      borrow_out_o <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      overflow_o   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            r_a      <= a_i;
            r_b      <= b_i;
            r_borrow <= borrow_in_i;
            r_cnt    <= '0;
            r_res    <= '0;
            busy_o   <= 1'b1;
            r_state  <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_a_msb  <= a_i[WIDTH-1];
            r_b_msb  <= b_i[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_res    <= w_res_nxt;
          r_borrow <= w_bout;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // Outputs change only here so partial results are never visible.
          if (w_last) begin
            diff_o       <= w_res_nxt;
            borrow_out_o <= w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow_o   <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
`endif
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl (WIDTH=8 main instance, WIDTH=1 corner instance).
// Define SERIAL_SUB_OVERFLOW_EN to also check overflow_o.

module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] a_i, b_i;
  logic       borrow_in_i;
  logic       busy_o, done_o, borrow_out_o;
  logic [7:0] diff_o;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       overflow_o;
  logic       ov1;
`endif

  logic start1, a1, b1, bin1;
  logic busy1, done1, d1, bo1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .borrow_in_i  (borrow_in_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .diff_o       (diff_o),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow_o   (overflow_o),
`endif
    .borrow_out_o (borrow_out_o)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start1),
    .a_i          (a1),
    .b_i          (b1),
    .borrow_in_i  (bin1),
    .busy_o       (busy1),
    .done_o       (done1),
    .diff_o       (d1),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow_o   (ov1),
`endif
    .borrow_out_o (bo1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one op on the 8-bit DUT and wait (bounded) for done_o.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int busy_cycles, output bit got_done);
    @(negedge clk);
    a_i = a; b_i = b; borrow_in_i = bin; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    busy_cycles = 0;
    got_done = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      if (done_o) got_done = 1'b1;
      else begin
        if (busy_o) busy_cycles++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int  bc;
    bit  gd;
    int  pulses;
    logic [7:0] prev;
    logic [1:0] t;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[7] = '{8'h37, 8'h12, 1'b1, 8'h24, 1'b0, 1'b0};
    vecs[8] = '{8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0};

    start_i = 0; a_i = 0; b_i = 0; borrow_in_i = 0;
    start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
    rst = 1'b1;
    #3;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_diff", diff_o, 0);
    chk("reset_bout", borrow_out_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, bc, gd);
      chk($sformatf("v%0d_done", i), gd, 1);
      chk($sformatf("v%0d_busy_cycles", i), bc, 8);
      chk($sformatf("v%0d_diff", i), diff_o, vecs[i].d);
      chk($sformatf("v%0d_bout", i), borrow_out_o, vecs[i].bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk($sformatf("v%0d_ovf", i), overflow_o, vecs[i].ov);
`endif
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), done_o, 0);
      chk($sformatf("v%0d_diff_hold", i), diff_o, vecs[i].d);
    end

    // Second start mid-RUN must be ignored; outputs hold the previous result until DONE.
    prev = vecs[NV-1].d;
    @(negedge clk);
    a_i = 8'h10; b_i = 8'h01; borrow_in_i = 0; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    a_i = 8'h33; b_i = 8'h77; borrow_in_i = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    a_i = 8'hFF; start_i = 1;
    @(posedge clk); #1;
    start_i = 0; a_i = 8'h00;
    chk("ign_busy_mid", busy_o, 1);
    chk("ign_diff_held", diff_o, prev);
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      if (done_o) begin
        pulses++;
        chk("ign_diff", diff_o, 8'h0F);
        chk("ign_bout", borrow_out_o, 0);
      end else if (pulses == 0) begin
        chk("ign_diff_no_partial", diff_o, prev);
      end
      @(posedge clk); #1;
    end
    chk("ign_pulses", pulses, 1);

    // Reset mid-RUN at bit 4.
    @(negedge clk);
    a_i = 8'hC3; b_i = 8'h01; borrow_in_i = 0; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    repeat (4) @(posedge clk);
    #3;
    chk("abort_busy_pre", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_diff", diff_o, 0);
    chk("abort_bout", borrow_out_o, 0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    do_op(8'hAA, 8'h55, 1'b0, bc, gd);
    chk("restart_done", gd, 1);
    chk("restart_diff", diff_o, 8'h55);
    chk("restart_bout", borrow_out_o, 0);

    // WIDTH=1 instance: every truth-table entry, RUN lasts one edge.
    for (int i = 0; i < 8; i++) begin
      t = {1'b0, i[2]} - {1'b0, i[1]} - {1'b0, i[0]};
      @(negedge clk);
      a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      chk($sformatf("w1_%0d_busy", i), busy1, 1);
      @(posedge clk); #1;
      chk($sformatf("w1_%0d_done", i), done1, 1);
      chk($sformatf("w1_%0d_diff", i), d1, t[0]);
      chk($sformatf("w1_%0d_bout", i), bo1, t[1]);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
